// File: rtl/cache_mem_arbiter.sv
// Serialises icache/dcache line refills and dcache writebacks onto a single burst port.
// Define ARB_RR_EN to alternate between icache and dcache reads; otherwise dcache reads win.
module cache_mem_arbiter #(
  parameter int LINE_WORDS = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    i_req,
  input  logic [31:0]             i_addr,
  output logic                    i_ack,
  output logic                    i_rvalid,
  output logic                    i_rlast,
  output logic [31:0]             i_rdata,
  input  logic                    d_rreq,
  input  logic [31:0]             d_raddr,
  output logic                    d_rack,
  output logic                    d_rvalid,
  output logic                    d_rlast,
  output logic [31:0]             d_rdata,
  input  logic                    d_wreq,
  input  logic [31:0]             d_waddr,
  input  logic [32*LINE_WORDS-1:0] d_wline,
  output logic                    d_wack,
  output logic                    read_en,
  output logic [31:0]             read_addr,
  output logic [31:0]             read_length,
  input  logic                    rd_accept,
  input  logic                    beat_valid,
  input  logic                    beat_last,
  input  logic [31:0]             beat_data,
  output logic                    write_en,
  output logic [31:0]             write_addr,
  output logic [31:0]             write_length,
  input  logic                    wr_accept,
  input  logic                    wbeat_ready,
  output logic [31:0]             wbeat_data,
  output logic                    wbeat_last,
  input  logic                    wr_done,
  output logic                    err,
  output logic [2:0]              dbg_state
);

  localparam int                  OFF_BITS  = $clog2(LINE_WORDS * 4);
  localparam int                  CNT_BITS  = $clog2(LINE_WORDS);
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(LINE_WORDS - 1);
  localparam logic [31:0]         LINE_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
  localparam logic [31:0]         BURST_LEN = 32'(LINE_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } state_t;

  state_t              state;
  logic                owner_d;
  logic [CNT_BITS-1:0] beat_cnt;
  logic [31:0]         line_buf [LINE_WORDS];
  logic                grant_w;
  logic                grant_d;
  logic                grant_i;
  logic                rd_fwd;
`ifdef ARB_RR_EN
  logic                last_d;
`endif

  // Grant candidates; only acted on in IDLE. Writebacks always go first.
  always_comb begin
    grant_w = d_wreq;
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (!d_wreq) begin
`ifdef ARB_RR_EN
      if (d_rreq && i_req) begin
        grant_d = !last_d;
        grant_i = last_d;
      end else begin
        grant_d = d_rreq;
        grant_i = i_req;
      end
`else
      grant_d = d_rreq;
      grant_i = i_req && !d_rreq;
`endif
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      beat_cnt     <= '0;
      err          <= 1'b0;
      i_ack        <= 1'b0;
      d_rack       <= 1'b0;
      d_wack       <= 1'b0;
      read_en      <= 1'b0;
      write_en     <= 1'b0;
      read_addr    <= '0;
      write_addr   <= '0;
      read_length  <= '0;
      write_length <= '0;
`ifdef ARB_RR_EN
      last_d       <= 1'b0;
`endif
    end else begin
      i_ack  <= 1'b0;
      d_rack <= 1'b0;
      d_wack <= 1'b0;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (grant_w) begin
            write_addr   <= d_waddr & LINE_MASK;
            write_length <= BURST_LEN;
            write_en     <= 1'b1;
            d_wack       <= 1'b1;
            state        <= WR_REQ;
          end else if (grant_d || grant_i) begin
            read_addr   <= (grant_d ? d_raddr : i_addr) & LINE_MASK;
            read_length <= BURST_LEN;
            read_en     <= 1'b1;
            owner_d     <= grant_d;
            d_rack      <= grant_d;
            i_ack       <= grant_i;
            state       <= RD_REQ;
`ifdef ARB_RR_EN
            last_d      <= grant_d;
`endif
          end
        end
        RD_REQ: begin
          if (rd_accept) begin
            read_en <= 1'b0;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (beat_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
            // A last flag on the wrong beat, or a missing one on the final beat, is a protocol error.
            if (beat_last != (beat_cnt == LAST_BEAT)) err <= 1'b1;
            if (beat_last) state <= IDLE;
          end
        end
        WR_REQ: begin
          if (wr_accept) begin
            write_en <= 1'b0;
            state    <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (wbeat_ready) begin
            if (beat_cnt == LAST_BEAT) state <= WR_RESP;
            else beat_cnt <= beat_cnt + 1'b1;
          end
        end
        WR_RESP: begin
          if (wr_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line buffer frees the dcache's writeback buffer at grant time.
  always_ff @(posedge aclk) begin
    if (state == IDLE && grant_w) begin
      for (int w = 0; w < LINE_WORDS; w++) line_buf[w] <= d_wline[w*32 +: 32];
    end
  end

  assign rd_fwd     = (state == RD_DATA) && beat_valid;
  assign i_rvalid   = rd_fwd && !owner_d;
  assign d_rvalid   = rd_fwd && owner_d;
  assign i_rlast    = i_rvalid && beat_last;
  assign d_rlast    = d_rvalid && beat_last;
  assign i_rdata    = i_rvalid ? beat_data : '0;
  assign d_rdata    = d_rvalid ? beat_data : '0;
  assign wbeat_data = (state == WR_DATA) ? line_buf[beat_cnt] : '0;
  assign wbeat_last = (state == WR_DATA) && (beat_cnt == LAST_BEAT);
  assign dbg_state  = state;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: cache drivers, an AXI-master responder with a static memory,
// and a monitor that checks every beat/ack against expected queues.
module tb_cache_mem_arbiter;

  localparam int LW  = 8;
  localparam int TMO = 500;

  logic              aclk, aresetn;
  logic              i_req, i_ack, i_rvalid, i_rlast;
  logic [31:0]       i_addr, i_rdata;
  logic              d_rreq, d_rack, d_rvalid, d_rlast;
  logic [31:0]       d_raddr, d_rdata;
  logic              d_wreq, d_wack;
  logic [31:0]       d_waddr;
  logic [32*LW-1:0]  d_wline;
  logic              read_en, rd_accept, beat_valid, beat_last;
  logic [31:0]       read_addr, read_length, beat_data;
  logic              write_en, wr_accept, wbeat_ready, wbeat_last, wr_done;
  logic [31:0]       write_addr, write_length, wbeat_data;
  logic              err;
  logic [2:0]        dbg_state;

  cache_mem_arbiter #(.LINE_WORDS(LW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rdata(i_rdata),
    .d_rreq(d_rreq), .d_raddr(d_raddr), .d_rack(d_rack),
    .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rdata(d_rdata),
    .d_wreq(d_wreq), .d_waddr(d_waddr), .d_wline(d_wline), .d_wack(d_wack),
    .read_en(read_en), .read_addr(read_addr), .read_length(read_length),
    .rd_accept(rd_accept), .beat_valid(beat_valid), .beat_last(beat_last), .beat_data(beat_data),
    .write_en(write_en), .write_addr(write_addr), .write_length(write_length),
    .wr_accept(wr_accept), .wbeat_ready(wbeat_ready), .wbeat_data(wbeat_data),
    .wbeat_last(wbeat_last), .wr_done(wr_done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_i_q[$];
  logic [32:0] exp_d_q[$];
  logic [32:0] exp_w_q[$];
  logic [31:0] exp_waddr_q[$];
  logic [1:0]  grant_log[$];
  int          short_len = LW;
  int          ready_mode = 0;
  int          wr_beats = 0;
  logic [31:0] last_raddr = '0;
  time         t_wr_done = 0;
  time         t_rd_rise = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~(32'(LW * 4) - 32'd1);
  endfunction

  // Static backing memory served by the responder.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input int k);
    if (line == 32'h1000_0000) return 32'hA0 + 32'(k);
    return line ^ (32'(k) * 32'h0101_0101) ^ 32'h3C3C_0000;
  endfunction

  function automatic logic [32*LW-1:0] rand_line();
    logic [32*LW-1:0] v;
    for (int k = 0; k < LW; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cache_read(input bit is_d, input logic [31:0] a, input int nbeats, output int lat);
    logic [31:0] line;
    logic        ack;
    line = line_of(a);
    for (int k = 0; k < nbeats; k++) begin
      if (is_d) exp_d_q.push_back({k == nbeats - 1, mem_word(line, k)});
      else      exp_i_q.push_back({k == nbeats - 1, mem_word(line, k)});
    end
    @(negedge aclk);
    if (is_d) begin d_rreq = 1'b1; d_raddr = a; end
    else      begin i_req  = 1'b1; i_addr  = a; end
    lat = 0;
    do begin
      @(negedge aclk); #2;
      lat++;
      ack = is_d ? d_rack : i_ack;
    end while (!ack && lat < TMO);
    if (!ack) begin
      if (is_d) check("d_rack_timeout", 64'(ack), 64'(1));
      else      check("i_ack_timeout", 64'(ack), 64'(1));
    end
    @(negedge aclk);
    if (is_d) begin d_rreq = 1'b0; d_raddr = $urandom; end
    else      begin i_req  = 1'b0; i_addr  = $urandom; end
  endtask

  task automatic d_write(input logic [31:0] a, input logic [32*LW-1:0] line, output int lat);
    for (int k = 0; k < LW; k++) exp_w_q.push_back({k == LW - 1, line[k*32 +: 32]});
    exp_waddr_q.push_back(line_of(a));
    @(negedge aclk);
    d_wreq = 1'b1; d_waddr = a; d_wline = line;
    lat = 0;
    do begin
      @(negedge aclk); #2;
      lat++;
    end while (!d_wack && lat < TMO);
    if (!d_wack) check("d_wack_timeout", 64'(d_wack), 64'(1));
    @(negedge aclk);
    d_wreq = 1'b0; d_waddr = $urandom; d_wline = rand_line();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_i_q.size() + exp_d_q.size() + exp_w_q.size() != 0 || dbg_state != 3'd0) && n < TMO) begin
      @(negedge aclk); #2;
      n++;
    end
    if (n >= TMO) check("drain_timeout", 64'(n), 64'(0));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (cycles) @(negedge aclk);
    #2;
    exp_i_q.delete(); exp_d_q.delete(); exp_w_q.delete(); exp_waddr_q.delete(); grant_log.delete();
    @(negedge aclk);
    aresetn = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl", 64'({i_ack, i_rvalid, i_rlast, d_rack, d_rvalid, d_rlast, d_wack,
                           read_en, write_en, wbeat_last, err}), 64'(0));
    check("rst_addr", {read_addr, write_addr}, 64'(0));
    check("rst_len", {read_length, write_length}, 64'(0));
    check("rst_rdata", {i_rdata, d_rdata}, 64'(0));
    check("rst_wdata", 64'(wbeat_data), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
  endtask

  // ---------------- AXI master responder ----------------
  initial begin : axi_model
    int          rd_phase, rd_cnt, rd_len, wr_phase, resp_wait;
    logic [31:0] rd_base;
    logic        alt, rdy;
    rd_phase = 0; rd_cnt = 0; rd_len = LW; wr_phase = 0; resp_wait = 0;
    rd_base = '0; alt = 1'b1; rdy = 1'b0;
    rd_accept = 0; beat_valid = 0; beat_last = 0; beat_data = 0;
    wr_accept = 0; wbeat_ready = 0; wr_done = 0;
    forever begin
      @(negedge aclk);
      rd_accept = 0; beat_valid = 0; beat_last = 0; beat_data = 0;
      wr_accept = 0; wbeat_ready = 0; wr_done = 0;
      if (aresetn) begin
        rd_phase = 0; wr_phase = 0; wr_beats = 0;
      end else begin
        if (rd_phase == 0) begin
          if (read_en && $urandom_range(0, 1) == 1) begin
            rd_accept = 1; rd_phase = 1; rd_cnt = 0; rd_base = read_addr; rd_len = short_len;
            last_raddr = read_addr;
          end
        end else if ($urandom_range(0, 3) != 0) begin
          beat_valid = 1;
          beat_data  = mem_word(rd_base, rd_cnt);
          beat_last  = (rd_cnt == rd_len - 1);
          rd_cnt++;
          if (beat_last) rd_phase = 0;
        end
        if (wr_phase == 0) begin
          if (write_en && $urandom_range(0, 1) == 1) begin
            wr_accept = 1; wr_phase = 1; wr_beats = 0; alt = 1'b1;
          end
        end else if (wr_phase == 1) begin
          case (ready_mode)
            0:       rdy = 1'($urandom_range(0, 1));
            1:       rdy = alt;
            default: rdy = 1'b1;
          endcase
          alt = ~alt;
          if (rdy) begin
            wbeat_ready = 1;
            wr_beats++;
            if (wr_beats == LW) begin
              wr_phase  = 2;
              resp_wait = $urandom_range(0, 3);
            end
          end
        end else if (resp_wait == 0) begin
          wr_done = 1; wr_phase = 0;
        end else begin
          resp_wait--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [32:0] e;
    logic        p_i_ack, p_d_rack, p_d_wack, p_read_en;
    bit          rd_busy, wr_busy;
    p_i_ack = 0; p_d_rack = 0; p_d_wack = 0; p_read_en = 0; rd_busy = 0; wr_busy = 0;
    forever begin
      @(negedge aclk); #2;
      if (aresetn) begin
        rd_busy = 0; wr_busy = 0;
      end else begin
        if (i_rvalid) begin
          if (exp_i_q.size() == 0) check("i_beat_unexpected", 64'(i_rvalid), 64'(0));
          else begin e = exp_i_q.pop_front(); check("i_beat", 64'({i_rlast, i_rdata}), 64'(e)); end
        end
        if (d_rvalid) begin
          if (exp_d_q.size() == 0) check("d_beat_unexpected", 64'(d_rvalid), 64'(0));
          else begin e = exp_d_q.pop_front(); check("d_beat", 64'({d_rlast, d_rdata}), 64'(e)); end
        end
        if (wbeat_ready) begin
          if (exp_w_q.size() == 0) check("wbeat_unexpected", 64'(wbeat_ready), 64'(0));
          else begin e = exp_w_q.pop_front(); check("wbeat", 64'({wbeat_last, wbeat_data}), 64'(e)); end
        end
        if (read_en && rd_accept) begin
          check("rd_single_burst", 64'(wr_busy), 64'(0));
          check("read_length", 64'(read_length), 64'(LW));
          rd_busy = 1;
        end
        if (beat_valid && beat_last) rd_busy = 0;
        if (write_en && wr_accept) begin
          check("wr_single_burst", 64'(rd_busy), 64'(0));
          check("write_length", 64'(write_length), 64'(LW));
          if (exp_waddr_q.size() == 0) check("write_unexpected", 64'(write_en), 64'(0));
          else check("write_addr", 64'(write_addr), 64'(exp_waddr_q.pop_front()));
          wr_busy = 1;
        end
        if (wr_done) begin wr_busy = 0; t_wr_done = $time; end
        if (read_en && !p_read_en) t_rd_rise = $time;
        if (i_ack)  begin check("i_ack_pulse", 64'(p_i_ack), 64'(0));  grant_log.push_back(2'd0); end
        if (d_rack) begin check("d_rack_pulse", 64'(p_d_rack), 64'(0)); grant_log.push_back(2'd1); end
        if (d_wack) begin check("d_wack_pulse", 64'(p_d_wack), 64'(0)); grant_log.push_back(2'd2); end
      end
      p_i_ack = i_ack; p_d_rack = d_rack; p_d_wack = d_wack; p_read_en = read_en;
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int               lat, lat_i, lat_d, n, nd, ni;
    logic             last_d_m, pick_d;
    logic [1:0]       exp_log[$];
    logic [32*LW-1:0] line;

    aresetn = 1'b1;
    i_req = 0; i_addr = 0; d_rreq = 0; d_raddr = 0; d_wreq = 0; d_waddr = 0; d_wline = '0;
    repeat (3) @(negedge aclk);
    #2;
    check_reset_outputs();
    @(negedge aclk);
    aresetn = 1'b0;

    // Icache refill of a mid-line address.
    cache_read(1'b0, 32'h1000_0014, LW, lat);
    check("i_ack_latency", 64'(lat), 64'(1));
    drain();
    check("t1_read_addr", 64'(last_raddr), 64'(32'h1000_0000));

    // Writeback with ready on every other cycle; FSM holds until wr_done.
    ready_mode = 1;
    for (int k = 0; k < LW; k++) line[k*32 +: 32] = 32'(k);
    d_write(32'h2000_0020, line, lat);
    check("d_wack_latency", 64'(lat), 64'(1));
    n = 0;
    while (!wr_done && n < TMO) begin @(negedge aclk); #2; n++; end
    check("wr_done_seen", 64'(wr_done), 64'(1));
    check("busy_until_wr_done", 64'(dbg_state != 3'd0), 64'(1));
    @(negedge aclk); #2;
    check("idle_after_wr_done", 64'(dbg_state), 64'(0));
    ready_mode = 0;

    // Writeback and refill of the same line raised together.
    fork
      d_write(32'h2400_0040, rand_line(), lat_d);
      cache_read(1'b1, 32'h2400_0048, LW, lat_i);
    join
    drain();
    check("wb_before_refill", 64'(t_rd_rise > t_wr_done), 64'(1));

    // Arbitration between continuously requesting caches, from a fresh reset.
    do_reset(2);
    fork
      begin for (int r = 0; r < 4; r++) cache_read(1'b1, 32'h5000_0000 + 32'(r * 64), LW, lat_d); end
      begin for (int r = 0; r < 2; r++) cache_read(1'b0, 32'h6000_0000 + 32'(r * 64), LW, lat_i); end
    join
    drain();
    nd = 4; ni = 2; last_d_m = 1'b0;
    while (nd + ni > 0) begin
      if (nd > 0 && ni > 0) begin
`ifdef ARB_RR_EN
        pick_d = !last_d_m;
`else
        pick_d = 1'b1;
`endif
      end else begin
        pick_d = (nd > 0);
      end
      last_d_m = pick_d;
      if (pick_d) nd--; else ni--;
      exp_log.push_back(pick_d ? 2'd1 : 2'd0);
    end
    check("arb_count", 64'(grant_log.size()), 64'(exp_log.size()));
    for (int g = 0; g < exp_log.size() && g < grant_log.size(); g++)
      check("arb_order", 64'(grant_log[g]), 64'(exp_log[g]));

    // Random concurrent traffic from both caches.
    fork
      begin
        repeat (12) begin
          repeat ($urandom_range(0, 6)) @(negedge aclk);
          cache_read(1'b0, $urandom, LW, lat_i);
        end
      end
      begin
        repeat (16) begin
          repeat ($urandom_range(0, 6)) @(negedge aclk);
          if ($urandom_range(0, 1) == 1) d_write($urandom, rand_line(), lat_d);
          else cache_read(1'b1, $urandom, LW, lat_d);
        end
      end
    join
    drain();
    check("err_clean", 64'(err), 64'(0));

    // Early beat_last on the 6th beat.
    short_len = 6;
    cache_read(1'b0, 32'h4000_0100, 6, lat);
    n = 0;
    while (!i_rlast && n < TMO) begin @(negedge aclk); #2; n++; end
    check("short_last_seen", 64'(i_rlast), 64'(1));
    short_len = LW;
    @(negedge aclk); #2;
    check("err_set", 64'(err), 64'(1));
    check("idle_after_short", 64'(dbg_state), 64'(0));
    cache_read(1'b1, $urandom, LW, lat);
    drain();
    check("err_sticky", 64'(err), 64'(1));

    // Reset in the middle of a writeback.
    ready_mode = 2;
    d_write(32'h7000_0000, rand_line(), lat);
    n = 0;
    while (wr_beats != 3 && n < TMO) begin @(negedge aclk); #2; n++; end
    check("wr_beat3_reached", 64'(wr_beats), 64'(3));
    aresetn = 1'b1;
    @(negedge aclk); #2;
    check_reset_outputs();
    exp_w_q.delete(); exp_waddr_q.delete();
    @(negedge aclk);
    aresetn = 1'b0;
    ready_mode = 0;
    cache_read(1'b0, 32'h3000_0044, LW, lat);
    check("post_reset_ack_latency", 64'(lat), 64'(1));
    drain();

    check("final_queues", 64'(exp_i_q.size() + exp_d_q.size() + exp_w_q.size() + exp_waddr_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates line-granularity memory requests from the instruction cache and data cache and drives the burst request interface of the AXI master stage directly downstream. Serialises one burst at a time, latches dirty-line writeback data into a local line buffer, streams it out beat by beat, and steers returning read beats to the requesting cache. Writebacks are always ordered ahead of refills, so a refill never overtakes a writeback to the same line.

## Interface
- LINE_WORDS, 8, words per cache line / beats per burst; power of two, 2..16
- aclk  in  1  clock
- aresetn  in  1  synchronous, active-high reset (sampled on rising aclk; high = reset)
- i_req  in  1  icache refill request; held until i_ack
- i_addr  in  32  icache miss address
- i_ack  out  1  one-cycle pulse: icache request accepted
- i_rvalid / i_rlast  out  1 / 1  refill beat valid / final beat to icache
- i_rdata  out  32  refill beat data to icache
- d_rreq  in  1  dcache refill request; held until d_rack
- d_raddr  in  32  dcache miss address
- d_rack  out  1  one-cycle pulse: dcache refill accepted
- d_rvalid / d_rlast  out  1 / 1  refill beat valid / final beat to dcache
- d_rdata  out  32  refill beat data to dcache
- d_wreq  in  1  dcache writeback request; held until d_wack
- d_waddr  in  32  writeback line address
- d_wline  in  32*LINE_WORDS  writeback line, word 0 in bits [31:0]
- d_wack  out  1  one-cycle pulse: line latched, dcache buffer free
- read_en  out  1  read burst request to AXI master
- read_addr  out  32  line-aligned read address
- read_length  out  32  burst length in beats (= LINE_WORDS)
- rd_accept  in  1  AXI master took read request
- beat_valid / beat_last  in  1 / 1  read beat valid / final beat
- beat_data  in  32  read beat data
- write_en  out  1  write burst request to AXI master
- write_addr  out  32  line-aligned write address
- write_length  out  32  burst length in beats (= LINE_WORDS)
- wr_accept  in  1  AXI master took write request
- wbeat_ready  in  1  AXI master consumes wbeat_data this cycle
- wbeat_data  out  32  current write beat
- wbeat_last  out  1  current write beat is final
- wr_done  in  1  write response received
- err  out  1  sticky: beat_last disagreed with beat count

## Operation
- FSM states: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_RESP.
- IDLE grant priority: d_wreq > reads. Reads: dcache before icache unless ARB_RR_EN (see Configuration).
- On grant: latch address with low log2(LINE_WORDS*4) bits cleared. Set owner (I/D). For writeback, latch d_wline into line buffer. Clear beat counter.
- RD_REQ: read_en=1 until rd_accept, then RD_DATA.
- RD_DATA: x_rvalid = beat_valid and owner==x; x_rdata = beat_data; x_rlast = beat_last. Counter increments per beat.
  - On beat_last: go to IDLE.
  - If beat_last arrives with counter ≠ LINE_WORDS-1, or counter reaches LINE_WORDS-1 without beat_last: set err. The FSM still exits on beat_last.
- WR_REQ: write_en=1 until wr_accept, then WR_DATA.
- WR_DATA: wbeat_data = buffer[counter]; wbeat_last = (counter==LINE_WORDS-1). Advance on wbeat_ready. The last beat consumed moves the FSM to WR_RESP.
- WR_RESP: wait for wr_done, then IDLE.
- Exactly one burst outstanding; new requests wait in IDLE.

## Timing
- Reset: state IDLE. All outputs 0, including err, read_addr/write_addr, and lengths. Buffer contents don't care.
- Grant decided in IDLE on edge E. Ack pulse and read_en/write_en both high in the cycle after E. Requester drops its req at the next edge.
- read_en/write_en drop in the cycle after accept. A same-cycle accept gives a one-cycle request.
- Beat forwarding is combinational, zero latency. No backpressure toward the caches; each cache must accept every beat.
- Minimum gap from beat_last or wr_done to the next grant: one cycle (one IDLE cycle).
- Requests arriving while busy: held, evaluated in IDLE.
- d_wreq and d_rreq both pending: write first, read on a later IDLE visit.
- aresetn mid-burst: FSM returns to IDLE next edge; transfer abandoned. The AXI master shares the same reset.

## Configuration
- ARB_RR_EN defined: round-robin between icache and dcache reads. A last-served bit toggles on each read grant, and the side not last served wins ties. Writebacks are still first.
- Undefined: fixed dcache-read over icache-read priority.

## Test plan
- i_req, i_addr=0x1000_0014 → i_ack pulse; read_addr=0x1000_0000, read_length=8; 8 beats 0xA0..0xA7 appear on i_rdata with i_rlast on 0xA7; d_rvalid stays 0.
- d_wreq at 0x2000_0020 with line 0..7, wbeat_ready high every other cycle → d_wack one cycle after grant; 8 beats 0..7 emitted in order, wbeat_last on beat 7; IDLE only after wr_done.
- d_wreq and d_rreq to the same line in the same cycle → write burst completes (wr_done) before read_en rises.
- i_req and d_rreq held continuously for 4 grants → without ARB_RR_EN: D,D,D,D; with ARB_RR_EN: D,I,D,I.
- Read with beat_last on 6th beat → err=1 and sticky; FSM in IDLE next cycle.
- aresetn asserted during WR_DATA beat 3 → next cycle all outputs 0, state IDLE; a new i_req is granted normally after reset releases.
